// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Producer side of the ALU Operation/SrcA/SrcB interface, between ID and EX.
//   Decodes ALUOp/Funct3/Funct7 into an ALU operation code and selects the
//   operands. The result goes into a 2-entry skid buffer with valid/ready on
//   both sides. A flush clears buffered entries when the front end redirects.
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               synchronous clear of all buffered entries
//   in_valid/in_ready   ID-side handshake (in_ready is registered)
//   ALUOp, Funct3,      decode inputs
//   Funct7, ALUSrc,
//   Jump
//   RD1, RD2, Imm       operand sources
//   out_valid/out_ready EX-side handshake for the head entry
//   Operation, SrcA,    head entry contents
//   SrcB, Illegal
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic                     ALUSrc,
  input  logic                     Jump,
  input  logic [DATA_WIDTH-1:0]    RD1,
  input  logic [DATA_WIDTH-1:0]    RD2,
  input  logic [DATA_WIDTH-1:0]    Imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     Illegal
);

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] op;
    logic [DATA_WIDTH-1:0]    a;
    logic [DATA_WIDTH-1:0]    b;
    logic                     ill;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;

  logic [3:0]            dec_op;
  logic                  dec_ill;
  logic                  dec_shift;
  logic [DATA_WIDTH-1:0] srcb_sel;
  entry_t                new_entry;
  logic                  push;
  logic                  pop;

  // Decode
  always_comb begin
    dec_op    = 4'b0000;
    dec_ill   = 1'b0;
    dec_shift = 1'b0;
    unique case (ALUOp)
      2'b00: dec_op = 4'b0011;
      2'b01: begin
        case (Funct3)
          3'b000:  dec_op = 4'b0101;
          3'b001:  dec_op = 4'b0110;
          3'b100:  dec_op = 4'b0111;
          3'b101:  dec_op = 4'b1000;
          default: dec_ill = 1'b1;
        endcase
      end
      2'b10: begin
        case (Funct3)
          3'b000:  dec_op = (!ALUSrc && Funct7 == 7'b0100000) ? 4'b0100 : 4'b0011;
          3'b111:  dec_op = 4'b0000;
          3'b100:  dec_op = 4'b0001;
          3'b110:  dec_op = 4'b0010;
          3'b010:  dec_op = 4'b0111;
          3'b001: begin
            if (Funct7 == 7'b0000000) begin
              dec_op    = 4'b1010;
              dec_shift = 1'b1;
            end else begin
              dec_ill = 1'b1;
            end
          end
          3'b101: begin
            if (Funct7 == 7'b0000000) begin
              dec_op    = 4'b1001;
              dec_shift = 1'b1;
            end else if (Funct7 == 7'b0100000) begin
              dec_op    = 4'b1011;
              dec_shift = 1'b1;
            end else begin
              dec_ill = 1'b1;
            end
          end
          default: dec_ill = 1'b1;
        endcase
      end
      2'b11: dec_op = Jump ? 4'b1111 : 4'b1100;
    endcase
  end

  // Operands. A shift uses only the low five bits of B, zero-extended.
  always_comb begin
    srcb_sel      = ALUSrc ? Imm : RD2;
    new_entry.op  = OPCODE_LENGTH'(dec_op);
    new_entry.a   = RD1;
    new_entry.b   = dec_shift ? DATA_WIDTH'(srcb_sel[4:0]) : srcb_sel;
    new_entry.ill = dec_ill;
  end

  assign push = in_valid && in_ready_q;
  assign pop  = (state_q != EMPTY) && out_ready;

  // Buffer next state
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = new_entry;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            tail_d  = new_entry;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            head_d = new_entry;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign Operation = head_q.op;
  assign SrcA      = head_q.a;
  assign SrcB      = head_q.b;
  assign Illegal   = head_q.ill;

endmodule
